// File: rtl/angle_rom_if.sv
// Command, ROM and output-stream signals of the angle ROM reader, bundled so the
// reader and its environment see one port each.
interface angle_rom_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 7,
    parameter int PHASE_WIDTH = 24,
    parameter int CNT_WIDTH   = 16
);
    logic                   start;
    logic [PHASE_WIDTH-1:0] phase_init;
    logic [PHASE_WIDTH-1:0] phase_inc;
    logic [CNT_WIDTH-1:0]   sample_cnt;
    logic                   abort;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [DATA_WIDTH-1:0]  rom_data;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   dout_last;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, phase_init, phase_inc, sample_cnt, abort, rom_data, dout_ready,
        output rom_addr, dout, dout_last, dout_valid, busy, done
    );

    modport slave (
        output start, phase_init, phase_inc, sample_cnt, abort, rom_data, dout_ready,
        input  rom_addr, dout, dout_last, dout_valid, busy, done
    );
endinterface

// File: rtl/angle_rom_reader.sv
// Sweeps a phase accumulator over a fixed-latency ROM and streams the captured
// samples through a 4-entry FWFT FIFO; address issue is credit-limited.
module angle_rom_reader #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 7,
    parameter int PHASE_WIDTH = 24,
    parameter int RD_LATENCY  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    angle_rom_if.master bus
);
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] inc_q, inc_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                   issue_q, issue_d;
    logic                   done_q, done_d;
    logic [RD_LATENCY-1:0]  pipe_valid_q, pipe_valid_d;
    logic [RD_LATENCY-1:0]  pipe_last_q, pipe_last_d;

    entry_t                 fifo_mem_q [FIFO_DEPTH];
    logic [1:0]             wr_ptr_q, wr_ptr_d;
    logic [1:0]             rd_ptr_q, rd_ptr_d;
    logic [2:0]             fifo_count_q, fifo_count_d;

    entry_t                 head;
    entry_t                 push_entry;
    logic                   fifo_valid;
    logic                   pop;
    logic                   push_en;
    logic                   pop_en;
    logic                   flush;
    logic                   credit_ok;

    assign head       = fifo_mem_q[rd_ptr_q];
    assign fifo_valid = (fifo_count_q != 3'd0);
    assign pop        = fifo_valid & bus.dout_ready;
    assign push_entry = '{last: pipe_last_q[RD_LATENCY-1], data: bus.rom_data};

    // Registered occupancy only: a pop in this cycle is deliberately not credited,
    // which keeps the worst case (two issues back to back) within four entries.
    assign credit_ok = (int'(fifo_count_q) + $countones(pipe_valid_q)) <= 2;

    // NOTE: every signal written here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        inc_d        = inc_q;
        remaining_d  = remaining_q;
        rom_addr_d   = rom_addr_q;
        issue_d      = 1'b0;
        done_d       = 1'b0;
        flush        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.sample_cnt != '0)) begin
                    state_d     = RUN;
                    acc_d       = bus.phase_init;
                    inc_d       = bus.phase_inc;
                    remaining_d = bus.sample_cnt;
                    rom_addr_d  = bus.phase_init[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    issue_d     = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else begin
                    if (issue_q) begin
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                        acc_d       = acc_q + inc_q;
                        rom_addr_d  = acc_d[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    end
                    if (remaining_d == '0) begin
                        state_d = DRAIN;
                    end else begin
                        issue_d = credit_ok;
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The ROM has no enable, so only the {valid,last} tag travels with the issue.
        pipe_valid_d[0] = issue_q & ~flush;
        pipe_last_d[0]  = issue_q & (remaining_q == CNT_WIDTH'(1));
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1] & ~flush;
            pipe_last_d[i]  = pipe_last_q[i-1];
        end

        push_en = pipe_valid_q[RD_LATENCY-1] & ~flush;
        pop_en  = pop & ~flush;

        if (flush) begin
            wr_ptr_d     = 2'd0;
            rd_ptr_d     = 2'd0;
            fifo_count_d = 3'd0;
        end else begin
            wr_ptr_d     = wr_ptr_q + 2'(push_en);
            rd_ptr_d     = rd_ptr_q + 2'(pop_en);
            fifo_count_d = fifo_count_q + 3'(push_en) - 3'(pop_en);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            inc_q        <= '0;
            remaining_q  <= '0;
            rom_addr_q   <= '0;
            issue_q      <= 1'b0;
            done_q       <= 1'b0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            remaining_q  <= remaining_d;
            rom_addr_q   <= rom_addr_d;
            issue_q      <= issue_d;
            done_q       <= done_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // NOTE: the storage array is not reset; the outputs below are gated by the
    // registered count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.dout       = fifo_valid ? head.data : '0;
    assign bus.dout_last  = fifo_valid & head.last;
    assign bus.dout_valid = fifo_valid;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule
